// File: rtl/matmul_tile_scheduler_pkg.sv
// Shared types, default geometry and helpers for the matmul tile scheduler.
package matmul_tile_scheduler_pkg;

  localparam int DEF_INPUT_DIM = 4;
  localparam int DEF_TILE_OUT  = 8;
  localparam int DEF_NUM_TILES = 4;
  localparam int DEF_PRECISION = 8;
  localparam int DEF_LATENCY   = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUTPUT
  } sched_state_t;

  typedef logic signed [DEF_PRECISION:0]  feat_t;
  typedef logic        [DEF_PRECISION-1:0] res_t;

  // Bank-select width; a single tile still needs one bit.
  function automatic int tile_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_tile_scheduler_if.sv
// Bundle of the input, datapath and output handshakes around the scheduler.
interface matmul_tile_scheduler_if #(
  parameter int INPUT_DIM = 4,
  parameter int TILE_OUT  = 8,
  parameter int NUM_TILES = 4,
  parameter int PRECISION = 8
);
  import matmul_tile_scheduler_pkg::*;

  localparam int TW = tile_w(NUM_TILES);

  logic                                         in_valid;
  logic                                         in_ready;
  logic [INPUT_DIM-1:0][PRECISION:0]            in_feature;
  logic [INPUT_DIM-1:0][PRECISION:0]            mm_feature;
  logic [TW-1:0]                                mm_tile_idx;
  logic                                         mm_issue;
  logic [TILE_OUT-1:0][PRECISION-1:0]           mm_result;
  logic                                         out_valid;
  logic                                         out_ready;
  logic [TILE_OUT*NUM_TILES-1:0][PRECISION-1:0] out_vector;
  logic [31:0]                                  vec_count;

  modport master (
    input  in_valid, in_feature, mm_result, out_ready,
    output in_ready, mm_feature, mm_tile_idx, mm_issue, out_valid, out_vector, vec_count
  );

  modport slave (
    output in_valid, in_feature, mm_result, out_ready,
    input  in_ready, mm_feature, mm_tile_idx, mm_issue, out_valid, out_vector, vec_count
  );

endinterface

// File: rtl/matmul_tile_scheduler_tile_valid_pipe.sv
// Delay line mirroring the datapath latency: carries {issue, tile index} to the capture point.
module matmul_tile_scheduler_tile_valid_pipe #(
  parameter int LATENCY = 2,
  parameter int TW      = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_i,
  input  logic [TW-1:0] idx_i,
  output logic          vld_o,
  output logic [TW-1:0] idx_o,
  output logic          busy_o
);

  logic [LATENCY-1:0]         vld_q;
  logic [LATENCY-1:0][TW-1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      idx_q[0] <= idx_i;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[LATENCY-1];
  assign idx_o  = idx_q[LATENCY-1];
  assign busy_o = |vld_q;

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Time-multiplexes one matmul datapath over NUM_TILES weight banks and assembles
// the full output vector for a valid/ready consumer.
module matmul_tile_scheduler
  import matmul_tile_scheduler_pkg::*;
#(
  parameter int INPUT_DIM = DEF_INPUT_DIM,
  parameter int TILE_OUT  = DEF_TILE_OUT,
  parameter int NUM_TILES = DEF_NUM_TILES,
  parameter int PRECISION = DEF_PRECISION,
  parameter int LATENCY   = DEF_LATENCY
) (
  input logic                     clk,
  input logic                     reset,
  matmul_tile_scheduler_if.master bus
);

  localparam int            TW        = tile_w(NUM_TILES);
  localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

  sched_state_t                                      state_q;
  logic [TW-1:0]                                     tile_q;
  logic                                              in_ready_q;
  logic                                              mm_issue_q;
  logic                                              out_valid_q;
  logic [INPUT_DIM-1:0][PRECISION:0]                 feat_q;
  logic [NUM_TILES-1:0][TILE_OUT-1:0][PRECISION-1:0] outv_q;
  logic [31:0]                                       vec_count_q;
  logic [31:0]                                       vec_count_d;

  logic          tail_vld;
  logic [TW-1:0] tail_idx;
  logic          pipe_busy;
  logic          drain_done;

  matmul_tile_scheduler_tile_valid_pipe #(
    .LATENCY (LATENCY),
    .TW      (TW)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (reset),
    .vld_i  (mm_issue_q),
    .idx_i  (tile_q),
    .vld_o  (tail_vld),
    .idx_o  (tail_idx),
    .busy_o (pipe_busy)
  );

  assign vec_count_d = vec_count_q + 32'd1;
  // Leave DRAIN on the same edge that captures the final tile, so out_valid is not delayed a cycle.
  assign drain_done  = (tail_vld && (tail_idx == LAST_TILE)) || !pipe_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tile_q      <= '0;
      in_ready_q  <= 1'b1;
      mm_issue_q  <= 1'b0;
      out_valid_q <= 1'b0;
      feat_q      <= '0;
      outv_q      <= '0;
      vec_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            feat_q     <= bus.in_feature;
            tile_q     <= '0;
            mm_issue_q <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (tile_q == LAST_TILE) begin
            tile_q     <= '0;
            mm_issue_q <= 1'b0;
            state_q    <= DRAIN;
          end else begin
            tile_q <= tile_q + TW'(1);
          end
        end
        DRAIN: begin
          if (drain_done) begin
            out_valid_q <= 1'b1;
            state_q     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            vec_count_q <= vec_count_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Capture point: the pipe tail lines up with mm_result for the same pass.
      if (tail_vld) begin
        outv_q[tail_idx] <= bus.mm_result;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.mm_feature  = feat_q;
  assign bus.mm_tile_idx = tile_q;
  assign bus.mm_issue    = mm_issue_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_vector  = outv_q;
  assign bus.vec_count   = vec_count_q;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for the tile scheduler: behavioural two-stage datapath with four banks, table-driven
// vectors, random vectors against a spec-level golden model, and reset/stall/wrap corner sequences.
module tb_matmul_tile_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matmul_tile_scheduler_if #(.INPUT_DIM(4), .TILE_OUT(8), .NUM_TILES(4), .PRECISION(8)) mif ();
  matmul_tile_scheduler_if #(.INPUT_DIM(4), .TILE_OUT(8), .NUM_TILES(1), .PRECISION(8)) mif1 ();

  matmul_tile_scheduler #(
    .INPUT_DIM(4), .TILE_OUT(8), .NUM_TILES(4), .PRECISION(8), .LATENCY(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  matmul_tile_scheduler #(
    .INPUT_DIM(4), .TILE_OUT(8), .NUM_TILES(1), .PRECISION(8), .LATENCY(2)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (mif1)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0]  exp_count;
  logic [255:0] last_vec;

  // Weight bank k, row j: one nonzero tap at input (j+k)%4 (gain 1 or 2), bias 16k+j.
  function automatic logic [7:0] bank(input logic [3:0][8:0] fv, input int k, input int j);
    int acc;
    int w;
    logic signed [8:0] e;
    acc = k * 16 + j;
    for (int i = 0; i < 4; i++) begin
      e = fv[i];
      w = (i == (j + k) % 4) ? ((j >= 4) ? 2 : 1) : 0;
      acc += w * int'(e);
    end
    return acc[7:0];
  endfunction

  function automatic logic [255:0] exp_vec(input logic [3:0][8:0] fv, input int nt);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < nt; k++)
      for (int j = 0; j < 8; j++)
        v[(k * 8 + j) * 8 +: 8] = bank(fv, k, j);
    return v;
  endfunction

  // Datapath model: result appears LATENCY=2 cycles after the pass; idle passes return poison.
  logic [7:0][7:0] dpa_s1, dpa_s2, dpb_s1, dpb_s2;
  always @(posedge clk) begin
    for (int j = 0; j < 8; j++) begin
      dpa_s1[j] <= mif.mm_issue  ? bank(mif.mm_feature,  int'(mif.mm_tile_idx),  j) : 8'hEE;
      dpb_s1[j] <= mif1.mm_issue ? bank(mif1.mm_feature, int'(mif1.mm_tile_idx), j) : 8'hEE;
    end
    dpa_s2 <= dpa_s1;
    dpb_s2 <= dpb_s1;
  end
  assign mif.mm_result  = dpa_s2;
  assign mif1.mm_result = dpb_s2;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mm_issue"},   mif.mm_issue,    0);
    chk({tag, "_mm_idx"},     mif.mm_tile_idx, 0);
    chk({tag, "_mm_feature"}, mif.mm_feature,  0);
    chk({tag, "_out_valid"},  mif.out_valid,   0);
    chk({tag, "_out_vector"}, mif.out_vector,  0);
    chk({tag, "_vec_count"},  mif.vec_count,   0);
  endtask

  // Entered and left at a negedge with the DUT idle; checks every cycle of one transaction.
  task automatic run_vec(input logic [3:0][8:0] feat, input int stall,
                         input logic [3:0][8:0] nxt, input logic hold);
    logic [255:0] ev;
    ev = exp_vec(feat, 4);
    mif.in_valid   = 1'b1;
    mif.in_feature = feat;
    mif.out_ready  = 1'b0;
    chk("idle_in_ready", mif.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (hold) mif.in_feature = nxt;
    else      mif.in_valid   = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("c%0d_in_ready", c), mif.in_ready, 0);
      chk($sformatf("c%0d_mm_issue", c), mif.mm_issue, (c <= 4) ? 1 : 0);
      if (c <= 4) chk($sformatf("c%0d_mm_idx", c), mif.mm_tile_idx, c - 1);
      chk($sformatf("c%0d_mm_feature", c), mif.mm_feature, feat);
      chk($sformatf("c%0d_out_valid", c), mif.out_valid, 0);
      @(negedge clk);
    end
    chk("c7_out_valid", mif.out_valid, 1);
    chk("c7_in_ready", mif.in_ready, 0);
    chk("c7_out_vector", mif.out_vector, ev);
    chk("c7_vec_count", mif.vec_count, exp_count);
    last_vec = mif.out_vector;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_out_valid", mif.out_valid, 1);
      chk("stall_out_vector", mif.out_vector, ev);
      chk("stall_in_ready", mif.in_ready, 0);
    end
    mif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mif.out_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    chk("post_out_valid", mif.out_valid, 0);
    chk("post_in_ready", mif.in_ready, 1);
    chk("post_vec_count", mif.vec_count, exp_count);
  endtask

  typedef struct {
    int         f[4];
    int         stall;
    bit         hold;
    logic [7:0] e0;
    logic [7:0] e31;
  } vec_rec_t;

  function automatic logic [3:0][8:0] pack(input vec_rec_t r);
    logic [3:0][8:0] fv;
    for (int i = 0; i < 4; i++) fv[i] = 9'(r.f[i]);
    return fv;
  endfunction

  initial begin
    vec_rec_t tab[4];
    logic [3:0][8:0] cur, nxt, fv1;
    logic [255:0] ev1;
    int st;
    logic hd;

    tab[0] = '{f: '{1, 2, 3, 4},       stall: 0,  hold: 1'b0, e0: 8'h01, e31: 8'h3D};
    tab[1] = '{f: '{-1, -2, -3, -4},   stall: 0,  hold: 1'b1, e0: 8'hFF, e31: 8'h31};
    tab[2] = '{f: '{255, -256, 0, 100}, stall: 0, hold: 1'b1, e0: 8'hFF, e31: 8'h37};
    tab[3] = '{f: '{0, 0, 0, 0},       stall: 20, hold: 1'b0, e0: 8'h00, e31: 8'h37};

    reset = 1'b0;
    mif.in_valid = 1'b0;  mif.in_feature = '0;  mif.out_ready = 1'b0;
    mif1.in_valid = 1'b0; mif1.in_feature = '0; mif1.out_ready = 1'b0;
    exp_count = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", mif.in_ready, 1);
    chk_reset_outputs("rel");

    // Table vectors: single, back-to-back with held in_valid, long out_ready stall.
    for (int t = 0; t < 4; t++) begin
      run_vec(pack(tab[t]), tab[t].stall, pack(tab[(t + 1) % 4]), tab[t].hold);
      chk($sformatf("tab%0d_e0", t), last_vec[7:0], tab[t].e0);
      chk($sformatf("tab%0d_e31", t), last_vec[255:248], tab[t].e31);
    end

    // Random vectors, random stalls and holds.
    for (int i = 0; i < 4; i++) cur[i] = 9'($urandom_range(0, 511));
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 4; i++) nxt[i] = 9'($urandom_range(0, 511));
      st = $urandom_range(0, 3);
      hd = 1'($urandom_range(0, 1));
      run_vec(cur, st, nxt, hd);
      cur = nxt;
    end

    // Reset during ISSUE at tile 2; in-flight passes must not land afterwards.
    mif.in_valid   = 1'b1;
    mif.in_feature = {9'd8, 9'd7, 9'd6, 9'd5};
    @(posedge clk);
    @(negedge clk);
    mif.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_idx_before_reset", mif.mm_tile_idx, 2);
    chk("mid_issue_before_reset", mif.mm_issue, 1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("mid");
    exp_count = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("after_rst_out_valid", mif.out_valid, 0);
      chk("after_rst_out_vector", mif.out_vector, 0);
      chk("after_rst_in_ready", mif.in_ready, 1);
      chk("after_rst_mm_issue", mif.mm_issue, 0);
    end
    for (int i = 0; i < 4; i++) cur[i] = 9'($urandom_range(0, 511));
    run_vec(cur, 1, cur, 1'b0);

    // Single-tile build: one ISSUE cycle, result in cycle 4.
    fv1 = {9'h1FF, 9'd3, 9'h1F9, 9'd9};
    ev1 = exp_vec(fv1, 1);
    mif1.in_valid   = 1'b1;
    mif1.in_feature = fv1;
    chk("nt1_in_ready", mif1.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    mif1.in_valid = 1'b0;
    chk("nt1_c1_issue", mif1.mm_issue, 1);
    chk("nt1_c1_idx", mif1.mm_tile_idx, 0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("nt1_c%0d_issue", c), mif1.mm_issue, 0);
      chk($sformatf("nt1_c%0d_idx", c), mif1.mm_tile_idx, 0);
      chk($sformatf("nt1_c%0d_out_valid", c), mif1.out_valid, 0);
    end
    @(negedge clk);
    chk("nt1_c4_out_valid", mif1.out_valid, 1);
    chk("nt1_c4_out_vector", mif1.out_vector, ev1);
    chk("nt1_c4_vec_count", mif1.vec_count, 0);
    mif1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mif1.out_ready = 1'b0;
    chk("nt1_post_out_valid", mif1.out_valid, 0);
    chk("nt1_post_vec_count", mif1.vec_count, 1);
    chk("nt1_post_in_ready", mif1.in_ready, 1);

    // Delivery count wraps from all-ones to zero.
    force dut.vec_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.vec_count_q;
    chk("wrap_preload", mif.vec_count, 32'hFFFF_FFFF);
    exp_count = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) cur[i] = 9'($urandom_range(0, 511));
    run_vec(cur, 0, cur, 1'b0);
    chk("wrap_zero", mif.vec_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
